// File: rtl/center_window_averager.sv
// Centre-of-screen window averager.
// Sums the R/G/B values of a 2^LOG2_W x 2^LOG2_H pixel window placed at
// (X0, Y0) once per frame. The result is the rounded mean of each channel.
// It is held on oR/oG/oB, and oVALID pulses for one cycle when it is fresh.
// If a frame starts while a window is still only partly collected, that
// window is abandoned and oDROP pulses for one cycle.
module center_window_averager #(
    parameter int X0     = 312,
    parameter int Y0     = 232,
    parameter int LOG2_W = 4,
    parameter int LOG2_H = 4
) (
    input  logic        CLK,
    input  logic        iRST_N,
    input  logic        iVAL,
    input  logic [15:0] H_CNT,
    input  logic [15:0] V_CNT,
    input  logic [7:0]  iR,
    input  logic [7:0]  iG,
    input  logic [7:0]  iB,
    output logic [7:0]  oR,
    output logic [7:0]  oG,
    output logic [7:0]  oB,
    output logic        oVALID,
    output logic        oDROP
);

    localparam int SH = LOG2_W + LOG2_H;   // log2 of pixels per window
    localparam int AW = 8 + SH;            // accumulator width, cannot overflow
    localparam int CW = SH + 1;            // pixel counter width
    localparam int SW = SH + 9;            // final sum width, includes rounding headroom

    localparam logic [15:0]   X_LO = 16'(X0);
    localparam logic [15:0]   X_HI = 16'(X0 + (1 << LOG2_W) - 1);
    localparam logic [15:0]   Y_LO = 16'(Y0);
    localparam logic [15:0]   Y_HI = 16'(Y0 + (1 << LOG2_H) - 1);
    localparam logic [CW-1:0] LAST = CW'((1 << SH) - 1);
    localparam logic [SW-1:0] HALF = SW'(1 << (SH - 1));

    typedef enum logic {
        WAIT_SOF,
        ACCUM
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_r_q, acc_r_d;
    logic [AW-1:0] acc_g_q, acc_g_d;
    logic [AW-1:0] acc_b_q, acc_b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    o_r_q, o_r_d;
    logic [7:0]    o_g_q, o_g_d;
    logic [7:0]    o_b_q, o_b_d;
    logic          valid_q, valid_d;
    logic          drop_q, drop_d;

    logic sof;
    logic inwin;

    // Rounded mean of one channel: add the last pixel to the running sum,
    // add half an LSB of the result, then shift out the window size.
    function automatic logic [7:0] avg_round(input logic [AW-1:0] acc,
                                             input logic [7:0]    pix);
        logic [SW-1:0] sum;
        sum = SW'(acc) + SW'(pix) + HALF;
        return 8'(sum >> SH);
    endfunction

    // Decode frame start and window membership of the current pixel.
    always_comb begin
        sof   = iVAL && (H_CNT == 16'd0) && (V_CNT == 16'd0);
        inwin = iVAL && (H_CNT >= X_LO) && (H_CNT <= X_HI) &&
                (V_CNT >= Y_LO) && (V_CNT <= Y_HI);
    end

    // Next-state logic: decide whether to restart, accumulate or finish the window.
    always_comb begin
        // NOTE: every signal gets its hold/idle value first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        acc_r_d = acc_r_q;
        acc_g_d = acc_g_q;
        acc_b_d = acc_b_q;
        cnt_d   = cnt_q;
        o_r_d   = o_r_q;
        o_g_d   = o_g_q;
        o_b_d   = o_b_q;
        valid_d = 1'b0;
        drop_d  = 1'b0;

        if (sof) begin
            // A frame start abandons any window still in progress. A pixel
            // that is both SOF and in-window is counted after the clear.
            drop_d  = (state_q == ACCUM);
            state_d = ACCUM;
            acc_r_d = inwin ? AW'(iR) : '0;
            acc_g_d = inwin ? AW'(iG) : '0;
            acc_b_d = inwin ? AW'(iB) : '0;
            cnt_d   = inwin ? CW'(1) : '0;
        end else if ((state_q == ACCUM) && inwin) begin
            if (cnt_q == LAST) begin
                o_r_d   = avg_round(acc_r_q, iR);
                o_g_d   = avg_round(acc_g_q, iG);
                o_b_d   = avg_round(acc_b_q, iB);
                valid_d = 1'b1;
                state_d = WAIT_SOF;
            end else begin
                acc_r_d = acc_r_q + AW'(iR);
                acc_g_d = acc_g_q + AW'(iG);
                acc_b_d = acc_b_q + AW'(iB);
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    // State, accumulator and output registers.
    always_ff @(posedge CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= WAIT_SOF;
            acc_r_q <= '0;
            acc_g_q <= '0;
            acc_b_q <= '0;
            cnt_q   <= '0;
            o_r_q   <= '0;
            o_g_q   <= '0;
            o_b_q   <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values from before this edge.
            state_q <= state_d;
            acc_r_q <= acc_r_d;
            acc_g_q <= acc_g_d;
            acc_b_q <= acc_b_d;
            cnt_q   <= cnt_d;
            o_r_q   <= o_r_d;
            o_g_q   <= o_g_d;
            o_b_q   <= o_b_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign oR     = o_r_q;
    assign oG     = o_g_q;
    assign oB     = o_b_q;
    assign oVALID = valid_q;
    assign oDROP  = drop_q;

endmodule

// File: tb/tb_center_window_averager.sv
// Randomised self-checking bench for center_window_averager.
// A queue-based model gathers the in-window pixels since the last frame start
// and averages them with plain integer arithmetic. Every cycle is compared
// against this model, and the scenarios listed in the test plan are also
// checked against fixed constants.
module tb_center_window_averager;

    localparam int X0 = 312;
    localparam int Y0 = 232;
    localparam int LOG2_W = 4;
    localparam int LOG2_H = 4;
    localparam int W = 1 << LOG2_W;
    localparam int H = 1 << LOG2_H;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        val = 1'b0;
    logic [15:0] h_cnt = '0;
    logic [15:0] v_cnt = '0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic [7:0]  o_r, o_g, o_b;
    logic        o_valid, o_drop;

    always #5 clk = ~clk;

    center_window_averager #(
        .X0(X0), .Y0(Y0), .LOG2_W(LOG2_W), .LOG2_H(LOG2_H)
    ) dut (
        .CLK(clk), .iRST_N(rst_n), .iVAL(val), .H_CNT(h_cnt), .V_CNT(v_cnt),
        .iR(r), .iG(g), .iB(b),
        .oR(o_r), .oG(o_g), .oB(o_b), .oVALID(o_valid), .oDROP(o_drop)
    );

    int n_checks = 0;
    int n_pass = 0;
    int pulse_cnt = 0;
    int drop_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: the in-window pixels seen since the last SOF.
    bit         m_armed = 0;
    int         q_r[$], q_g[$], q_b[$];
    logic [7:0] exp_r = '0, exp_g = '0, exp_b = '0;
    bit         exp_valid = 0, exp_drop = 0;

    function automatic int mean_round(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return (s + N / 2) / N;
    endfunction

    task automatic model_reset();
        m_armed = 0;
        q_r.delete(); q_g.delete(); q_b.delete();
        exp_r = '0; exp_g = '0; exp_b = '0;
        exp_valid = 0; exp_drop = 0;
    endtask

    task automatic model_step(input bit vl, input int hh, input int vv,
                              input int rr, input int gg, input int bb);
        bit sof, inwin;
        exp_valid = 0;
        exp_drop = 0;
        if (!vl) return;
        sof = (hh == 0) && (vv == 0);
        inwin = (hh >= X0) && (hh < X0 + W) && (vv >= Y0) && (vv < Y0 + H);
        if (sof) begin
            exp_drop = m_armed;
            m_armed = 1;
            q_r.delete(); q_g.delete(); q_b.delete();
        end
        if (inwin && m_armed) begin
            q_r.push_back(rr); q_g.push_back(gg); q_b.push_back(bb);
            if (q_r.size() == N) begin
                exp_r = 8'(mean_round(q_r));
                exp_g = 8'(mean_round(q_g));
                exp_b = 8'(mean_round(q_b));
                exp_valid = 1;
                m_armed = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check("o_r", o_r, exp_r);
        check("o_g", o_g, exp_g);
        check("o_b", o_b, exp_b);
        check("o_valid", o_valid, exp_valid);
        check("o_drop", o_drop, exp_drop);
        check("valid_drop_excl", o_valid & o_drop, 0);
        if (o_valid === 1'b1) pulse_cnt++;
        if (o_drop === 1'b1) drop_cnt++;
    endtask

    // One cycle: check the result of the previous edge, then drive new inputs.
    task automatic beat(input bit vl, input int hh, input int vv,
                        input int rr, input int gg, input int bb);
        @(negedge clk);
        check_outputs();
        val = vl; h_cnt = 16'(hh); v_cnt = 16'(vv);
        r = 8'(rr); g = 8'(gg); b = 8'(bb);
        model_step(vl, hh, vv, rr, gg, bb);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_outputs();
        val = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_o_r", o_r, 0);
        check("rst_o_g", o_g, 0);
        check("rst_o_b", o_b, 0);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_drop", o_drop, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive a sparse raster around the window with random idle gaps.
    // ones >= 0 replaces R of the first 'ones' window pixels with 1 and
    // the rest with 0. (skip_h, skip_v) is driven with iVAL low. If the
    // scan reaches row rst_v at column X0, reset is asserted there and the
    // rest of the frame is abandoned.
    task automatic frame(input bit sof, input int in_r, input int in_g, input int in_b,
                         input int out_v, input bit rnd, input int ones,
                         input int skip_h, input int skip_v, input int rst_v);
        int k = 0;
        if (sof) beat(1, 0, 0, out_v, out_v, out_v);
        for (int vv = Y0 - 4; vv < Y0 + H + 4; vv++) begin
            for (int hh = X0 - 4; hh < X0 + W + 4; hh++) begin
                bit inwin;
                int pr, pg, pb;
                if (vv == rst_v && hh == X0) begin
                    do_reset();
                    return;
                end
                if ($urandom_range(0, 7) == 0)
                    beat(0, $urandom_range(0, 15), $urandom_range(0, 15),
                         $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
                inwin = (hh >= X0) && (hh < X0 + W) && (vv >= Y0) && (vv < Y0 + H);
                if (inwin) begin
                    if (rnd) begin
                        pr = $urandom_range(0, 255);
                        pg = $urandom_range(0, 255);
                        pb = $urandom_range(0, 255);
                    end else begin
                        pr = in_r; pg = in_g; pb = in_b;
                    end
                    if (ones >= 0) pr = (k < ones) ? 1 : 0;
                    k++;
                end else if (rnd) begin
                    pr = $urandom_range(0, 255);
                    pg = $urandom_range(0, 255);
                    pb = $urandom_range(0, 255);
                end else begin
                    pr = out_v; pg = out_v; pb = out_v;
                end
                beat(!(hh == skip_h && vv == skip_v), hh, vv, pr, pg, pb);
            end
        end
        beat(0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_frame(input string tag, input int pulses, input int drops,
                                input int er, input int eg, input int eb);
        beat(0, 0, 0, 0, 0, 0);
        check({tag, "_pulses"}, pulse_cnt, pulses);
        check({tag, "_drops"}, drop_cnt, drops);
        check({tag, "_r"}, o_r, er);
        check({tag, "_g"}, o_g, eg);
        check({tag, "_b"}, o_b, eb);
        pulse_cnt = 0;
        drop_cnt = 0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_r", o_r, 0);
        check("reset_valid", o_valid, 0);
        check("reset_drop", o_drop, 0);
        rst_n = 1'b1;

        // A frame that never starts with SOF must be ignored.
        frame(0, 8'h44, 8'h44, 8'h44, 0, 0, -1, -1, -1, -1);
        expect_frame("no_sof", 0, 0, 0, 0, 0);

        frame(1, 8'h80, 8'h40, 8'hFF, 0, 0, -1, -1, -1, -1);
        expect_frame("uniform", 1, 0, 8'h80, 8'h40, 8'hFF);

        frame(1, 0, 0, 0, 0, 0, 128, -1, -1, -1);
        expect_frame("round_128", 1, 0, 8'h01, 0, 0);
        frame(1, 0, 0, 0, 0, 0, 127, -1, -1, -1);
        expect_frame("round_127", 1, 0, 0, 0, 0);
        frame(1, 8'hFF, 8'hFF, 8'hFF, 0, 0, -1, -1, -1, -1);
        expect_frame("all_ff", 1, 0, 8'hFF, 8'hFF, 8'hFF);

        frame(1, 8'h10, 8'h10, 8'h10, 8'hFF, 0, -1, -1, -1, -1);
        expect_frame("isolation", 1, 0, 8'h10, 8'h10, 8'h10);

        // Missing pixel: no result, and the next SOF reports the drop.
        frame(1, 8'h66, 8'h66, 8'h66, 0, 0, -1, 320, 240, -1);
        expect_frame("incomplete", 0, 0, 8'h10, 8'h10, 8'h10);
        frame(1, 8'h22, 8'h22, 8'h22, 0, 0, -1, -1, -1, -1);
        expect_frame("after_drop", 1, 1, 8'h22, 8'h22, 8'h22);

        frame(1, 8'h77, 8'h77, 8'h77, 0, 0, -1, -1, -1, 238);
        expect_frame("mid_reset", 0, 0, 0, 0, 0);
        frame(1, 8'h5A, 8'h5A, 8'h5A, 0, 0, -1, -1, -1, -1);
        expect_frame("post_reset", 1, 0, 8'h5A, 8'h5A, 8'h5A);

        frame(1, 8'h30, 8'h30, 8'h30, 0, 0, -1, -1, -1, -1);
        expect_frame("hold_a", 1, 0, 8'h30, 8'h30, 8'h30);
        frame(1, 8'h70, 8'h70, 8'h70, 0, 0, -1, -1, -1, -1);
        expect_frame("hold_b", 1, 0, 8'h70, 8'h70, 8'h70);

        // Random content, sometimes with a missing window pixel.
        for (int i = 0; i < 6; i++) begin
            bit skip = ($urandom_range(0, 2) == 0);
            frame(1, 0, 0, 0, 0, 1, -1,
                  skip ? X0 + int'($urandom_range(0, W - 1)) : -1,
                  skip ? Y0 + int'($urandom_range(0, H - 1)) : -1, -1);
        end
        beat(0, 0, 0, 0, 0, 0);
        beat(0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
